// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid buffer,
// synchronous flush to a bubble value and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
    parameter int                 SKID      = 1,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        occupancy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and a presented payload stays stable until taken.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_stall;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_emit;

    assign w_out_valid = (r_state != S_EMPTY);
    // In skid mode in_ready comes from a flop, so out_ready never reaches it combinationally.
    assign in_ready    = (SKID != 0) ? r_in_ready : (!w_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_emit      = w_out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = NOP_VALUE;
            w_skid_nxt  = NOP_VALUE;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                S_ONE: begin
                    if (w_accept && !w_emit) begin
                        if (SKID != 0) begin
                            w_state_nxt = S_TWO;
                            w_skid_nxt  = in_data;
                        end else begin
                            w_main_nxt  = in_data;
                        end
                    end else if (w_emit && !w_accept) begin
                        // Main register returns to the bubble so out_data never shows stale data.
                        w_state_nxt = S_EMPTY;
                        w_main_nxt  = NOP_VALUE;
                    end else if (w_emit && w_accept) begin
                        w_main_nxt  = in_data;
                    end
                end
                S_TWO: begin
                    if (w_emit) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = NOP_VALUE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_main_nxt  = NOP_VALUE;
                    w_skid_nxt  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_EMPTY;
            r_main     <= NOP_VALUE;
            r_skid     <= NOP_VALUE;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_state_nxt != S_TWO);
        end
    end

    // Flush leaves the stall counter alone; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
        end else if (w_out_valid && !out_ready && (r_stall != CNT_MAX)) begin
            r_stall <= r_stall + CNT_ONE;
        end
    end

    assign out_valid = w_out_valid;
    assign out_data  = r_main;
    assign stall_cnt = r_stall;
    assign occupancy = r_state;

endmodule
